// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO address map, seven-segment CTRL layout and reset value
package mmio_pkg;

    // Peripheral window: the top-level decoder routes any address matching
    // MMIO_WIN_BASE under MMIO_WIN_MASK to peripherals instead of DMEM.
    localparam logic [31:0] MMIO_WIN_BASE = 32'h1001_0000;
    localparam logic [31:0] MMIO_WIN_MASK = 32'hFFFF_0000;

    localparam logic [31:0] MMIO_SEG_DATA = 32'h1001_4000;
    localparam logic [31:0] MMIO_SEG_CTRL = MMIO_SEG_DATA + 32'd4;

    typedef struct packed {
        logic       blank;
        logic [7:0] mask;
    } seg_ctrl_t;

    localparam seg_ctrl_t SEG_CTRL_RST = 9'h0FF;

    function automatic logic is_mmio(input logic [31:0] a);
        return (a & MMIO_WIN_MASK) == MMIO_WIN_BASE;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: hex nibble to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}, dp off
//   nib_i  in  4  hex digit
//   seg_o  out 8  active-low segment cathodes
module hex7seg (
    input  logic [3:0] nib_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = 8'hFF;
        case (nib_i)
            4'h0: seg_o = 8'hC0;
            4'h1: seg_o = 8'hF9;
            4'h2: seg_o = 8'hA4;
            4'h3: seg_o = 8'hB0;
            4'h4: seg_o = 8'h99;
            4'h5: seg_o = 8'h92;
            4'h6: seg_o = 8'h82;
            4'h7: seg_o = 8'hF8;
            4'h8: seg_o = 8'h80;
            4'h9: seg_o = 8'h90;
            4'hA: seg_o = 8'h88;
            4'hB: seg_o = 8'h83;
            4'hC: seg_o = 8'hC6;
            4'hD: seg_o = 8'hA1;
            4'hE: seg_o = 8'h86;
            4'hF: seg_o = 8'h8E;
            default: seg_o = 8'hFF;
        endcase
    end

endmodule

// File: rtl/seg7_mmio.sv
// seg7_mmio: memory-mapped 8-digit multiplexed seven-segment display (DATA/CTRL registers)
//   clk    in  1   system clock
//   rst    in  1   synchronous active-high reset
//   we     in  1   store strobe
//   addr   in  32  byte address
//   wdata  in  32  store data
//   rdata  out 32  combinational read data
//   an     out 8   digit enables, active-low, digit 0 rightmost
//   seg    out 8   segment cathodes, active-low {dp,g,f,e,d,c,b,a}
module seg7_mmio
    import mmio_pkg::*;
#(
    parameter int          SCAN_DIV  = 100000,
    parameter logic [31:0] BASE_ADDR = MMIO_SEG_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    logic [31:0]   data_q, data_d;
    seg_ctrl_t     ctrl_q, ctrl_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    digit_idx_q, digit_idx_d;
    logic [7:0]    an_q, an_d, seg_q, seg_d;
    logic [7:0]    hex_seg;
    logic          sel_data, sel_ctrl, tick, dark;

    assign sel_data = addr == BASE_ADDR && addr[1:0] == 2'b00;
    assign sel_ctrl = addr == BASE_ADDR + 32'd4 && addr[1:0] == 2'b00;
    assign tick     = div_cnt_q == DW'(SCAN_DIV - 1);

    assign rdata = sel_data ? data_q : sel_ctrl ? {23'b0, ctrl_q} : 32'b0;

    hex7seg u_hex (
        .nib_i (data_q[4*digit_idx_q +: 4]),
        .seg_o (hex_seg)
    );

    // The output register follows the registered scan position and register
    // contents, so a store or tick at edge N shows up on the pins after N+1.
    always_comb begin
        data_d      = we && sel_data ? wdata : data_q;
        ctrl_d      = we && sel_ctrl ? seg_ctrl_t'(wdata[8:0]) : ctrl_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DW'(1);
        digit_idx_d = digit_idx_q + 3'(tick);
        dark        = ctrl_q.blank || !ctrl_q.mask[digit_idx_q];
        an_d        = dark ? 8'hFF : ~(8'b1 << digit_idx_q);
        seg_d       = dark ? 8'hFF : {1'b1, hex_seg[6:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            ctrl_q      <= SEG_CTRL_RST;
            div_cnt_q   <= '0;
            digit_idx_q <= '0;
            an_q        <= 8'hFF;
            seg_q       <= 8'hFF;
        end else begin
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_mmio.sv
// tb_seg7_mmio: directed plus randomized check of seg7_mmio against a cycle-count reference model
module tb_seg7_mmio;

    localparam int          SD   = 4;
    localparam logic [31:0] BASE = 32'h1001_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  an, seg;

    int total = 0;
    int bad = 0;

    logic [7:0]  tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] m_data = '0;
    logic [8:0]  m_ctrl = 9'h0FF;
    int          k = 0;
    bit          known = 0;
    logic [7:0]  e_an, e_seg;

    seg7_mmio #(.SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return a == BASE ? m_data : a == BASE + 32'd4 ? {23'b0, m_ctrl} : 32'b0;
    endfunction

    // One clock cycle: drive, check rdata, advance model at the edge, check pins.
    // Digit shown at the k-th edge after reset = number of completed SD-cycle
    // slots before that edge, modulo 8.
    task automatic cyc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int dg;
        rst = r; we = w; addr = a; wdata = d;
        #1;
        if (known) begin
            total++;
            assert (rdata === m_read(a)) else begin
                bad++;
                $error("FAIL rdata addr=%h got=%h want=%h", a, rdata, m_read(a));
            end
        end
        @(posedge clk);
        if (r) begin
            m_data = '0; m_ctrl = 9'h0FF; k = 0; known = 1;
            e_an = 8'hFF; e_seg = 8'hFF;
        end else begin
            k++;
            dg = ((k - 1) / SD) % 8;
            if (m_ctrl[8] || !m_ctrl[dg]) begin
                e_an = 8'hFF; e_seg = 8'hFF;
            end else begin
                e_an = 8'hFF ^ (8'd1 << dg);
                e_seg = tbl[(m_data >> (4 * dg)) & 32'hF];
            end
            if (w && a == BASE) m_data = d;
            if (w && a == BASE + 32'd4) m_ctrl = d[8:0];
        end
        #1;
        total++;
        assert (an === e_an && seg === e_seg) else begin
            bad++;
            $error("FAIL scan k=%0d got an=%h seg=%h want an=%h seg=%h", k, an, seg, e_an, e_seg);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE + 32'd4, 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rd;
        int          sel;
        // reset held 3 cycles
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, BASE, 32'h0);
        total++;
        assert (an === 8'hFF && seg === 8'hFF) else begin
            bad++; $error("FAIL reset_out got an=%h seg=%h want an=ff seg=ff", an, seg);
        end
        idle(1);
        total++;
        assert (an === 8'hFE && seg === 8'hC0) else begin
            bad++; $error("FAIL first_digit got an=%h seg=%h want an=fe seg=c0", an, seg);
        end
        addr = BASE + 32'd4; #1;
        total++;
        assert (rdata === 32'h0000_00FF) else begin
            bad++; $error("FAIL ctrl_reset got=%h want=000000ff", rdata);
        end
        // full frame of DATA
        cyc(1'b0, 1'b1, BASE, 32'h1234_ABCD);
        idle(2 * 8 * SD);
        addr = BASE; #1;
        total++;
        assert (rdata === 32'h1234_ABCD) else begin
            bad++; $error("FAIL data_rb got=%h want=1234abcd", rdata);
        end
        // digit mask and blank
        cyc(1'b0, 1'b1, BASE + 32'd4, 32'h0000_0005);
        idle(8 * SD + 3);
        cyc(1'b0, 1'b1, BASE + 32'd4, 32'h0000_01FF);
        idle(8 * SD);
        addr = BASE + 32'd4; #1;
        total++;
        assert (rdata === 32'h0000_01FF) else begin
            bad++; $error("FAIL blank_rb got=%h want=000001ff", rdata);
        end
        // ignored stores
        cyc(1'b0, 1'b1, BASE + 32'd1, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, BASE + 32'd8, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF);
        cyc(1'b0, 1'b1, BASE + 32'd6, 32'hFFFF_FFFF);
        addr = BASE + 32'd8; #1;
        total++;
        assert (rdata === 32'h0) else begin
            bad++; $error("FAIL oow_read got=%h want=0", rdata);
        end
        addr = BASE; #1;
        total++;
        assert (rdata === 32'h1234_ABCD) else begin
            bad++; $error("FAIL data_kept got=%h want=1234abcd", rdata);
        end
        // tick into digit 0 coinciding with a write to nibble 0
        cyc(1'b0, 1'b1, BASE + 32'd4, 32'h0000_00FF);
        while (k % (8 * SD) != 8 * SD - 1) idle(1);
        cyc(1'b0, 1'b1, BASE, 32'h1234_ABCF);
        idle(1);
        total++;
        assert (an === 8'hFE && seg === 8'h8E) else begin
            bad++; $error("FAIL tick_write got an=%h seg=%h want an=fe seg=8e", an, seg);
        end
        // reset mid-frame at digit 5, div_cnt 2
        while (k % (8 * SD) != 5 * SD + 2) idle(1);
        cyc(1'b1, 1'b0, BASE, 32'h0);
        for (int i = 0; i < SD; i++) begin
            idle(1);
            total++;
            assert (an === 8'hFE && seg === 8'hC0) else begin
                bad++; $error("FAIL restart slot%0d got an=%h seg=%h want an=fe seg=c0", i, an, seg);
            end
        end
        idle(1);
        total++;
        assert (an === 8'hFD) else begin
            bad++; $error("FAIL restart_next got an=%h want=fd", an);
        end
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            ra = sel < 3 ? BASE : sel < 5 ? BASE + 32'd4 : sel == 5 ? BASE + 32'($urandom_range(1, 3)) :
                 sel == 6 ? BASE + 32'd8 : sel == 7 ? BASE - 32'd4 : sel == 8 ? BASE + 32'd5 : $urandom;
            rd = $urandom;
            if (sel < 5 && rd[0]) rd[8] = 1'b0;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, ra, rd);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_mmio.md
# seg7_mmio

Memory-mapped seven-segment display peripheral on the CPU data bus, alongside DMEM. It captures CPU word stores to two MMIO registers and time-multiplexes an 8-digit common-anode hex display. Loads from those addresses return the register contents. The top level steers `addr`/`we` here when the CPU address falls in the MMIO window instead of DMEM.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per digit slot; minimum 2.
- `BASE_ADDR`, default 32'h1001_4000: byte address of the DATA register; CTRL is at BASE_ADDR+4.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `we`  in  1  CPU store strobe (DM_W-equivalent), sampled at the clock edge.
- `addr`  in  32  CPU byte address (same value the CPU drives toward DMEM).
- `wdata`  in  32  store data.
- `rdata`  out  32  combinational read data.
- `an`  out  8  digit enables, active-low; bit i selects digit i (digit 0 rightmost).
- `seg`  out  8  segment cathodes, active-low, packed {dp,g,f,e,d,c,b,a}.

## Operation
Registers:
- DATA[31:0]: eight hex nibbles; nibble i is shown on digit i.
- CTRL[8:0]: [7:0] = digit enable mask; [8] = blank-all. Bits [31:9] read 0 and ignore writes. Reset value 9'h0FF.

Writes:
- Accepted when `we`=1, `addr` = BASE_ADDR or BASE_ADDR+4, and `addr[1:0]`=0. The register updates at that edge.
- Any other address, or misaligned addresses within the window, are ignored with no side effect. No partial-word writes.

Reads:
- `rdata` = DATA when `addr`=BASE_ADDR; {23'b0,CTRL} when `addr`=BASE_ADDR+4; otherwise 0.
- Purely combinational, same cycle.

Scan engine:
- Prescaler `div_cnt` counts 0..SCAN_DIV-1. A tick occurs in the cycle where `div_cnt`=SCAN_DIV-1; `div_cnt` then wraps to 0.
- A 3-bit `digit_idx` increments on each tick and wraps 7->0.
- Output register, updated every cycle outside reset:
  - if CTRL[8]=1 or CTRL[digit_idx]=0: `an`=8'hFF, `seg`=8'hFF.
  - otherwise: `an`=~(1<<digit_idx), `seg`=hex7seg(DATA[4*digit_idx+:4]) with dp off (bit 7 = 1).
- hex7seg encodings (active-low, {dp..a}):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E

## Timing
- Reset (`rst`=1 at an edge): DATA=0, CTRL=9'h0FF, `div_cnt`=0, `digit_idx`=0, `an`=8'hFF, `seg`=8'hFF. Reset mid-scan aborts immediately, with no partial-digit carry-over.
- First cycle after reset release: the output register loads digit 0, so `an`=8'hFE and `seg`=8'hC0 are visible one edge after reset drops.
- Write-to-display latency: a store at edge N updates DATA at N. If the written digit is currently selected, `an`/`seg` reflect it after edge N+1; otherwise they reflect it when that digit is next scanned.
- Tick and write in the same cycle: both take effect. The output at the next edge uses the new `digit_idx` and the new DATA/CTRL.
- Each digit is active for exactly SCAN_DIV cycles, so the full frame is 8*SCAN_DIV cycles.
- `rdata` has zero latency and reflects register state as of the last edge. A read in the same cycle as a write to the same address returns the old value.

## Structure
- Shared package `mmio_pkg` holds:
  - MMIO_SEG_DATA and MMIO_SEG_CTRL address constants;
  - CTRL reset value 9'h0FF;
  - the MMIO window base used by the top-level decoder to route between DMEM and peripherals.
- One combinational sub-module `hex7seg` (4-bit in, 8-bit active-low out). It is reused by later display peripherals.
- Everything else (register file, prescaler, scan counter, output register) lives in `seg7_mmio`.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset: hold `rst` 3 cycles, release. Then `an`=FF/`seg`=FF during reset, `an`=FE/`seg`=C0 at the first edge after release, and `rdata` at BASE+4 is 0x000000FF.
- Store DATA=32'h1234_ABCD at BASE. Then `rdata`=32'h1234ABCD, and over one 32-cycle frame `seg` cycles through A1,C6,83,88,99,B0,A4,F9 with `an` FE,FD,FB,…,7F, each held 4 cycles.
- Store CTRL=32'h0000_0005. Digits 0 and 2 light; the other slots show `an`=FF/`seg`=FF. Readback is 0x00000005. Then store CTRL=32'h0000_01FF: every slot is dark, and `rdata` returns 0x000001FF.
- Misaligned/out-of-window stores: `we` to BASE+1, BASE+8 and BASE-4 with data 32'hFFFF_FFFF leave DATA and CTRL unchanged. `rdata` is 0 at BASE+8.
- Simultaneous tick and write: store nibble 0 = F so that the write edge coincides with the tick into digit 0. At the next edge `an`=FE and `seg`=8E.
- Reset mid-frame (`digit_idx`=5, `div_cnt`=2): `rst` for one cycle restores all reset values. Scanning restarts at digit 0 with a full 4-cycle slot.
